// File: rtl/adpll_pkg.sv
// Shared ADPLL definitions: phase-detector FSM states and default sizing constants.
package adpll_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_FB  = 2'd1,
      WAIT_REF = 2'd2
   } pd_state_e;

   localparam int unsigned CNT_W_DEF    = 8;
   localparam int unsigned LOCK_TOL_DEF = 2;
   localparam int unsigned LOCK_CNT_DEF = 8;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchronizer plus rising-edge detector producing a registered one-cycle pulse.
module edge_sync (
   input  logic clk,
   input  logic reset,
   input  logic sig_i,
   output logic rise_o
);

   logic       sync1_q, sync2_q, prev_q, rise_q;
   logic [1:0] fill_q;

   // fill_q suppresses detection until the chain holds real samples, so a
   // level that is already high when reset drops is not seen as an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         rise_q  <= 1'b0;
         fill_q  <= 2'd0;
      end else begin
         sync1_q <= sig_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         if (fill_q != 2'd3) fill_q <= fill_q + 2'd1;
         rise_q  <= (fill_q == 2'd3) & sync2_q & ~prev_q;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/phase_detector_tdc.sv
// Counter-based time-to-digital phase detector: measures ref-to-fb edge interval in clk cycles
// and tracks lock from consecutive small errors.
module phase_detector_tdc
   import adpll_pkg::*;
#(
   parameter int unsigned CNT_W    = CNT_W_DEF,
   parameter int unsigned LOCK_TOL = LOCK_TOL_DEF,
   parameter int unsigned LOCK_CNT = LOCK_CNT_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic                    ref_in,
   input  logic                    fb_in,
   output logic signed [CNT_W-1:0] phase_err,
   output logic                    err_valid,
   output logic                    up,
   output logic                    dn,
   output logic                    locked
);

   localparam int unsigned LOCK_W = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0]  CNT_SAT = CNT_W'((1 << (CNT_W - 1)) - 1);
   localparam logic [CNT_W-1:0]  TOL     = CNT_W'(LOCK_TOL);
   localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CNT);

   logic ref_rise, fb_rise;

   edge_sync u_ref_sync (.clk(clk), .reset(reset), .sig_i(ref_in), .rise_o(ref_rise));
   edge_sync u_fb_sync  (.clk(clk), .reset(reset), .sig_i(fb_in),  .rise_o(fb_rise));

   pd_state_e                state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d, cnt_inc;
   logic signed [CNT_W-1:0]  err_q, err_d;
   logic                     ev_q, ev_d, up_q, up_d, dn_q, dn_d, locked_q, locked_d;
   logic [LOCK_W-1:0]        lock_q, lock_d;
   logic [CNT_W-1:0]         err_mag;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         err_q    <= '0;
         ev_q     <= 1'b0;
         up_q     <= 1'b0;
         dn_q     <= 1'b0;
         lock_q   <= '0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         ev_q     <= ev_d;
         up_q     <= up_d;
         dn_q     <= dn_d;
         lock_q   <= lock_d;
         locked_q <= locked_d;
      end
   end

   assign cnt_inc = (cnt_q >= CNT_SAT) ? CNT_SAT : cnt_q + CNT_W'(1);

   // Next-state and measurement logic; the closing edge wins over a repeated opening edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      ev_d    = 1'b0;
      up_d    = up_q;
      dn_d    = dn_q;
      if (!enable) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (ref_rise && fb_rise) begin
                  err_d = '0;
                  ev_d  = 1'b1;
                  up_d  = 1'b0;
                  dn_d  = 1'b0;
               end else if (ref_rise) begin
                  state_d = WAIT_FB;
                  cnt_d   = CNT_W'(1);
               end else if (fb_rise) begin
                  state_d = WAIT_REF;
                  cnt_d   = CNT_W'(1);
               end
            end
            WAIT_FB: begin
               if (fb_rise || ref_rise) begin
                  err_d = fb_rise ? $signed(cnt_q) : $signed(CNT_SAT);
                  ev_d  = 1'b1;
                  up_d  = 1'b1;
                  dn_d  = 1'b0;
                  cnt_d = CNT_W'(1);
                  if (!ref_rise) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            WAIT_REF: begin
               if (ref_rise || fb_rise) begin
                  err_d = ref_rise ? -$signed(cnt_q) : -$signed(CNT_SAT);
                  ev_d  = 1'b1;
                  up_d  = 1'b0;
                  dn_d  = 1'b1;
                  cnt_d = CNT_W'(1);
                  if (!fb_rise) begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   assign err_mag = err_q[CNT_W-1] ? $unsigned(-err_q) : $unsigned(err_q);

   // Lock tracking runs on the registered result, so locked follows err_valid by one cycle.
   always_comb begin
      lock_d = lock_q;
      if (!enable) begin
         lock_d = '0;
      end else if (ev_q) begin
         if (err_mag <= TOL) begin
            if (lock_q < LOCK_MAX) lock_d = lock_q + LOCK_W'(1);
         end else begin
            lock_d = '0;
         end
      end
      locked_d = (lock_d == LOCK_MAX);
   end

   assign phase_err = err_q;
   assign err_valid = ev_q;
   assign up        = up_q;
   assign dn        = dn_q;
   assign locked    = locked_q;

endmodule

// File: tb/tb_phase_detector_tdc.sv
// Self-checking bench for phase_detector_tdc: vector table, corner sequences and randomized
// measurements against an interval/lock reference model.
module tb_phase_detector_tdc;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              enable = 1'b1;
   logic              ref_in = 1'b0;
   logic              fb_in = 1'b0;
   logic signed [7:0] phase_err;
   logic              err_valid, up, dn, locked;

   phase_detector_tdc dut (
      .clk(clk), .reset(reset), .enable(enable), .ref_in(ref_in), .fb_in(fb_in),
      .phase_err(phase_err), .err_valid(err_valid), .up(up), .dn(dn), .locked(locked)
   );

   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      int err;
      bit up;
      bit dn;
      bit lk;
   } ev_t;

   typedef struct {
      int lead;     // 0: ref first, 1: fb first
      int gap;      // 0: both edges in the same cycle
      int exp_err;
   } vec_t;

   ev_t evq[$];
   int  cyc = 0;
   int  n_chk = 0;
   int  n_pass = 0;
   int  lcnt = 0;
   int  last_start = 0;

   // Result monitor: captures every err_valid pulse with its cycle number.
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (err_valid) evq.push_back('{cyc, int'(phase_err), up, dn, locked});
   end

   task automatic chk(input string nm, input int act, input int exp_v);
      n_chk++;
      if (act == exp_v) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
   endtask

   // Reference lock model: counts consecutive in-tolerance results.
   function automatic void model_lock(input int err);
      int mag;
      mag = (err < 0) ? -err : err;
      if (mag <= 2) lcnt = (lcnt < 8) ? lcnt + 1 : 8;
      else lcnt = 0;
   endfunction

   function automatic int model_err(input int lead, input int gap);
      int mag;
      mag = (gap > 127) ? 127 : gap;
      return (lead == 0) ? mag : -mag;
   endfunction

   // Drive one-cycle input pulses at given offsets (-1 = unused), then let results settle.
   task automatic pulses(input int r0, input int r1, input int f0, input int f1, input int n);
      evq.delete();
      last_start = cyc;
      for (int c = 0; c < n; c++) begin
         ref_in = (c == r0) || (c == r1);
         fb_in  = (c == f0) || (c == f1);
         @(negedge clk);
      end
      ref_in = 1'b0;
      fb_in  = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic check_ev(input string nm, input int idx, input int t_close, input int exp_err);
      if (evq.size() <= idx) begin
         chk({nm, "_present"}, evq.size(), idx + 1);
      end else begin
         chk({nm, "_err"}, evq[idx].err, exp_err);
         chk({nm, "_up"}, int'(evq[idx].up), int'(exp_err > 0));
         chk({nm, "_dn"}, int'(evq[idx].dn), int'(exp_err < 0));
         chk({nm, "_lat"}, evq[idx].cyc, last_start + t_close + 4);
      end
      model_lock(exp_err);
   endtask

   task automatic meas(input string nm, input int lead, input int gap, input int exp_err);
      pulses((lead == 1) ? gap : 0, -1, (lead == 0) ? gap : 0, -1, gap + 1);
      chk({nm, "_count"}, evq.size(), 1);
      check_ev(nm, 0, gap, exp_err);
      chk({nm, "_locked"}, int'(locked), int'(lcnt == 8));
   endtask

   vec_t vecs[9];

   initial begin
      vecs[0] = '{0, 5, 5};
      vecs[1] = '{1, 3, -3};
      vecs[2] = '{0, 0, 0};
      vecs[3] = '{1, 1, -1};
      vecs[4] = '{0, 127, 127};
      vecs[5] = '{1, 127, -127};
      vecs[6] = '{0, 200, 127};
      vecs[7] = '{1, 130, -127};
      vecs[8] = '{0, 1, 1};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_err", int'(phase_err), 0);
      chk("rst_flags", int'({err_valid, up, dn, locked}), 0);
      reset = 1'b0;
      repeat (8) @(negedge clk);

      // Table-driven measurements
      foreach (vecs[i]) meas($sformatf("vec%0d", i), vecs[i].lead, vecs[i].gap, vecs[i].exp_err);

      // Cycle slip: long wait saturates silently, second ref emits +127 and stays in WAIT_FB
      pulses(0, 300, 305, -1, 306);
      chk("slip_count", evq.size(), 2);
      check_ev("slip", 0, 300, 127);
      check_ev("slip_after", 1, 305, 5);

      // Closing and new opening edge together while waiting
      pulses(0, 10, 10, 14, 15);
      chk("both_wait_count", evq.size(), 2);
      check_ev("both_wait", 0, 10, 10);
      check_ev("both_wait_next", 1, 14, 4);

      // Lock acquisition and loss
      for (int k = 0; k < 8; k++) begin
         meas($sformatf("lock%0d", k), 0, 1, 1);
         if (k == 7 && evq.size() > 0) chk("lock_late", int'(evq[0].lk), 0);
      end
      chk("locked_after8", int'(locked), 1);
      meas("unlock", 0, 4, 4);
      chk("locked_after_big", int'(locked), 0);
      for (int k = 0; k < 8; k++) meas($sformatf("relock%0d", k), 1, 2, -2);

      // Enable dropped mid-measurement
      pulses(0, -1, -1, -1, 6);
      enable = 1'b0;
      pulses(-1, -1, 2, -1, 3);
      chk("en_no_ev", evq.size(), 0);
      chk("en_locked", int'(locked), 0);
      chk("en_hold_err", int'(phase_err), -2);
      chk("en_hold_dn", int'(dn), 1);
      lcnt = 0;
      enable = 1'b1;
      repeat (3) @(negedge clk);
      meas("en_resume", 0, 3, 3);

      // Async reset mid-WAIT_FB, with ref held high across release
      ref_in = 1'b1;
      @(negedge clk);
      ref_in = 1'b0;
      repeat (42) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midrst_err", int'(phase_err), 0);
      chk("midrst_flags", int'({err_valid, up, dn, locked}), 0);
      ref_in = 1'b1;
      lcnt = 0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (10) @(negedge clk);
      ref_in = 1'b0;
      repeat (4) @(negedge clk);
      meas("post_rst", 1, 2, -2);

      // Randomized measurements against the model
      for (int k = 0; k < 30; k++) begin
         int lead, gap;
         lead = int'($urandom_range(0, 1));
         gap  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 160));
         meas($sformatf("rnd%0d", k), lead, gap, model_err(lead, gap));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/phase_detector_tdc.md
PHASE_DETECTOR_TDC -- requirements
Module: phase_detector_tdc

Interface
REQ-001 Parameter CNT_W, default 8, width of the signed phase-error word and the internal interval counter.
REQ-002 Parameter LOCK_TOL, default 2, maximum |phase_err| in clk cycles that counts as in-lock.
REQ-003 Parameter LOCK_CNT, default 8, number of consecutive in-lock measurements needed to assert locked.
REQ-004 clk  input  1  system sampling clock; all logic is on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 enable  input  1  measurement enable; low forces IDLE.
REQ-007 ref_in  input  1  reference clock, asynchronous to clk.
REQ-008 fb_in  input  1  feedback clock from the programmable frequency divider output, asynchronous to clk.
REQ-009 phase_err  output  CNT_W  signed two's-complement ref-to-fb edge interval in clk cycles; positive means ref leads fb.
REQ-010 err_valid  output  1  single-cycle pulse that marks a new phase_err.
REQ-011 up  output  1  registered copy of the sign of the last valid phase_err when it is positive.
REQ-012 dn  output  1  registered copy of the sign of the last valid phase_err when it is negative.
REQ-013 locked  output  1  lock indicator.

Function
REQ-014 ref_in and fb_in SHALL each pass through a 2-flop synchronizer followed by a rising-edge detector, which produces ref_rise and fb_rise as one-cycle pulses.
REQ-015 FSM states SHALL be IDLE, WAIT_FB (ref led; awaiting fb) and WAIT_REF (fb led; awaiting ref).
REQ-016 In IDLE: ref_rise only -> WAIT_FB; fb_rise only -> WAIT_REF; both together -> phase_err=0 with err_valid, stay IDLE; the interval counter SHALL clear to 1 on entry to either WAIT state.
REQ-017 In a WAIT state the counter SHALL increment by 1 per clk and saturate at 2^(CNT_W-1)-1 (127 by default).
REQ-018 If the closing edge arrives in cycle t1 after the opening edge in cycle t0, then |phase_err| SHALL equal min(t1-t0, 127), with positive sign from WAIT_FB and negative sign from WAIT_REF, and the FSM SHALL return to IDLE.
REQ-019 phase_err, up and dn SHALL update, and err_valid SHALL pulse high, in cycle t1+1, one clk after the closing edge pulse.
REQ-020 If the opening edge repeats in a WAIT state (for example, ref_rise in WAIT_FB), this is a cycle slip: emit a saturated error (+127 or -128 clipped to -127) with err_valid, clear the counter to 1 and remain in the same WAIT state.
REQ-021 If the opening and closing edges occur in the same cycle while in a WAIT state, the closing edge SHALL take priority: emit the measurement and move to the WAIT state of the new opening edge with the counter at 1.
REQ-022 Counter saturation alone SHALL NOT emit a result; the FSM SHALL keep waiting.
REQ-023 On each err_valid, a lock counter SHALL increment (saturating at LOCK_CNT) if |phase_err| <= LOCK_TOL and clear to 0 otherwise; locked SHALL equal (lock counter == LOCK_CNT).
REQ-024 When enable is low, the FSM SHALL go to IDLE, the interval and lock counters SHALL clear, locked SHALL be 0 and err_valid SHALL be 0, while phase_err, up and dn hold; the synchronizers keep running.
REQ-025 up and dn SHALL never both be 1; both SHALL be 0 after a zero error.

Reset
REQ-026 Asynchronous reset SHALL clear the synchronizers, edge-detector history, FSM (to IDLE), both counters, phase_err, err_valid, up, dn and locked to 0, including mid-measurement.
REQ-027 The first edge detected after reset deasserts SHALL be treated as an opening edge; no false edge SHALL be reported because of the reset value.

Structure
REQ-028 Shared package adpll_pkg SHALL hold the FSM state enum (IDLE, WAIT_FB, WAIT_REF) and the default constants for CNT_W, LOCK_TOL and LOCK_CNT.
REQ-029 The synchronizer plus rising-edge detector SHALL be the sub-module edge_sync, instantiated twice.

Verification
REQ-030 Drive ref_rise at cycle 10 and fb_rise at cycle 15 -> phase_err=+5, up=1, dn=0, err_valid=1 at cycle 16 only.
REQ-031 Drive fb_rise at cycle 20 and ref_rise at cycle 23 -> phase_err=-3, dn=1; drive both in the same cycle from IDLE -> phase_err=0, up=dn=0.
REQ-032 Drive ref_rise with no fb for 300 cycles, then a second ref_rise -> a single err_valid with phase_err=+127; the FSM remains in WAIT_FB.
REQ-033 Apply 8 consecutive measurements of +1 -> locked rises on the 8th err_valid+1; then one measurement of +4 -> locked=0.
REQ-034 Assert reset in WAIT_FB at counter=40 -> all outputs are 0 immediately; after release, fb then ref 2 cycles apart -> phase_err=-2.
REQ-035 Drop enable mid-measurement -> no err_valid, locked=0, phase_err holds its last value.
